// File: rtl/dma_cfg_master_pkg.sv
// dma_pkg: register map, control bit positions and FSM encodings shared by the
// DMA configuration master, its timer and its bus interface.
package dma_pkg;

  // Byte offsets of the DMA register block
  localparam logic [31:0] REG_SRC   = 32'h00;
  localparam logic [31:0] REG_COUNT = 32'h04;
  localparam logic [31:0] REG_CTRL  = 32'h08;
  localparam logic [31:0] REG_DST   = 32'h0C;

  // Control word bit positions
  localparam int CTRL_EN  = 0;
  localparam int CTRL_DIR = 1;

  // Sequencer states; the RB_* states are only reachable with readback enabled
  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_SRC,
    S_RB_SRC,
    S_WR_CNT,
    S_RB_CNT,
    S_WR_DST,
    S_RB_DST,
    S_WR_CTRL,
    S_RB_CTRL,
    S_POLL_GAP,
    S_POLL_RD,
    S_WR_ABORT,
    S_FIN
  } state_t;

  // Which completion pulse the FIN cycle produces
  typedef enum logic [1:0] {
    FIN_DONE,
    FIN_TIMEOUT,
    FIN_ERR
  } fin_t;

  // Control word that starts a transfer in the given direction
  function automatic logic [31:0] ctrl_word(input logic dir);
    logic [31:0] word;
    word           = '0;
    word[CTRL_EN]  = 1'b1;
    word[CTRL_DIR] = dir;
    return word;
  endfunction

endpackage

// File: rtl/dma_cfg_master_if.sv
// dma_cfg_master_if: descriptor handshake, CPU register bus and status pulses
// of the DMA configuration master. The master modport is the sequencer's view;
// the slave modport is the view of the descriptor source plus register block.
interface dma_cfg_master_if;
  import dma_pkg::*;

  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] desc_src;
  logic [31:0] desc_dst;
  logic [31:0] desc_count;
  logic        desc_dir;
  logic        desc_wait;

  logic        cpu_wr_en;
  logic        cpu_rd_en;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wr_data;
  logic [31:0] cpu_rd_data;

  logic        busy;
  logic        done;
  logic        timeout;
  logic        err;

  modport master (
    input  desc_valid, desc_src, desc_dst, desc_count, desc_dir, desc_wait,
    input  cpu_rd_data,
    output desc_ready, cpu_wr_en, cpu_rd_en, cpu_addr, cpu_wr_data,
    output busy, done, timeout, err
  );

  modport slave (
    output desc_valid, desc_src, desc_dst, desc_count, desc_dir, desc_wait,
    output cpu_rd_data,
    input  desc_ready, cpu_wr_en, cpu_rd_en, cpu_addr, cpu_wr_data,
    input  busy, done, timeout, err
  );

endinterface

// File: rtl/dma_cfg_master_timer.sv
// dma_cfg_timer: loadable down-counter that saturates at zero. Used both for
// the idle gap between status reads and for the overall polling timeout.
module dma_cfg_timer
  import dma_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Load takes priority; otherwise count down while enabled, stopping at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/dma_cfg_master.sv
// dma_cfg_master: takes one DMA descriptor per handshake, programs source,
// count and destination, then the control word to start the transfer, and
// optionally polls the status word until done or timeout.
// Build option DMA_CFG_READBACK_EN: every register write is followed by a
// read of the same address; a mismatch ends the sequence with an err pulse.
module dma_cfg_master
  import dma_pkg::*;
#(
  parameter logic [31:0] STATUS_ADDR  = 32'h10,
  parameter int          DONE_BIT     = 0,
  parameter int          POLL_GAP     = 4,
  parameter int          POLL_TIMEOUT = 1024
) (
  input logic              clk,
  input logic              reset,
  dma_cfg_master_if.master bus
);

  state_t      state, next_state, post_ctrl;
  fin_t        fin_kind, next_fin;
  logic [31:0] src_q, cnt_q, dst_q;
  logic        dir_q, wait_q;
  logic        in_poll, gap_expired, tmo_expired;

  logic        wr_en_n, rd_en_n;
  logic [31:0] addr_n, wdata_n;
  logic        wr_en_q, rd_en_q, ready_q, busy_q, done_q, timeout_q;
  logic [31:0] addr_q, wdata_q;

  assign in_poll   = (state == S_POLL_GAP) || (state == S_POLL_RD);
  assign post_ctrl = wait_q ? S_POLL_GAP : S_FIN;

  dma_cfg_timer #(.WIDTH(32)) u_gap_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (state != S_POLL_GAP),
    .load_value (32'(POLL_GAP - 1)),
    .enable     (state == S_POLL_GAP),
    .expired    (gap_expired)
  );

  dma_cfg_timer #(.WIDTH(32)) u_tmo_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (!in_poll),
    .load_value (32'(POLL_TIMEOUT - 1)),
    .enable     (in_poll),
    .expired    (tmo_expired)
  );

  // Next-state logic; next_fin records which pulse the coming FIN cycle gives
  always_comb begin
    next_state = state;
    next_fin   = fin_kind;
    unique case (state)
      S_IDLE: begin
        if (bus.desc_valid) begin
          if (bus.desc_count == '0) begin
            next_state = S_FIN;
            next_fin   = FIN_DONE;
          end else begin
            next_state = S_WR_SRC;
          end
        end
      end
`ifdef DMA_CFG_READBACK_EN
      S_WR_SRC: next_state = S_RB_SRC;
      S_RB_SRC: begin
        if (bus.cpu_rd_data != src_q) begin
          next_state = S_FIN;
          next_fin   = FIN_ERR;
        end else begin
          next_state = S_WR_CNT;
        end
      end
      S_WR_CNT: next_state = S_RB_CNT;
      S_RB_CNT: begin
        if (bus.cpu_rd_data != cnt_q) begin
          next_state = S_FIN;
          next_fin   = FIN_ERR;
        end else begin
          next_state = S_WR_DST;
        end
      end
      S_WR_DST: next_state = S_RB_DST;
      S_RB_DST: begin
        if (bus.cpu_rd_data != dst_q) begin
          next_state = S_FIN;
          next_fin   = FIN_ERR;
        end else begin
          next_state = S_WR_CTRL;
        end
      end
      S_WR_CTRL: next_state = S_RB_CTRL;
      S_RB_CTRL: begin
        if (bus.cpu_rd_data[CTRL_DIR] != dir_q) begin
          next_state = S_WR_ABORT;
          next_fin   = FIN_ERR;
        end else begin
          next_state = post_ctrl;
          next_fin   = FIN_DONE;
        end
      end
`else
      S_WR_SRC: next_state = S_WR_CNT;
      S_WR_CNT: next_state = S_WR_DST;
      S_WR_DST: next_state = S_WR_CTRL;
      S_WR_CTRL: begin
        next_state = post_ctrl;
        next_fin   = FIN_DONE;
      end
`endif
      S_POLL_GAP: begin
        if (tmo_expired) begin
          next_state = S_WR_ABORT;
          next_fin   = FIN_TIMEOUT;
        end else if (gap_expired) begin
          next_state = S_POLL_RD;
        end
      end
      S_POLL_RD: begin
        if (bus.cpu_rd_data[DONE_BIT]) begin
          next_state = S_FIN;
          next_fin   = FIN_DONE;
        end else if (tmo_expired) begin
          next_state = S_WR_ABORT;
          next_fin   = FIN_TIMEOUT;
        end else begin
          next_state = S_POLL_GAP;
        end
      end
      S_WR_ABORT: next_state = S_FIN;
      S_FIN:      next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Bus operation for the upcoming state; WR_SRC is only entered from IDLE,
  // so its data comes straight from the descriptor being accepted
  always_comb begin
    wr_en_n = 1'b0;
    rd_en_n = 1'b0;
    addr_n  = '0;
    wdata_n = '0;
    unique case (next_state)
      S_WR_SRC:   begin wr_en_n = 1'b1; addr_n = REG_SRC;   wdata_n = bus.desc_src;      end
      S_RB_SRC:   begin rd_en_n = 1'b1; addr_n = REG_SRC;                                end
      S_WR_CNT:   begin wr_en_n = 1'b1; addr_n = REG_COUNT; wdata_n = cnt_q;             end
      S_RB_CNT:   begin rd_en_n = 1'b1; addr_n = REG_COUNT;                              end
      S_WR_DST:   begin wr_en_n = 1'b1; addr_n = REG_DST;   wdata_n = dst_q;             end
      S_RB_DST:   begin rd_en_n = 1'b1; addr_n = REG_DST;                                end
      S_WR_CTRL:  begin wr_en_n = 1'b1; addr_n = REG_CTRL;  wdata_n = ctrl_word(dir_q);  end
      S_RB_CTRL:  begin rd_en_n = 1'b1; addr_n = REG_CTRL;                               end
      S_POLL_RD:  begin rd_en_n = 1'b1; addr_n = STATUS_ADDR;                            end
      S_WR_ABORT: begin wr_en_n = 1'b1; addr_n = REG_CTRL;  wdata_n = '0;                end
      default: ;
    endcase
  end

  // State register plus registered bus and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      fin_kind  <= FIN_DONE;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= next_state;
      fin_kind  <= next_fin;
      wr_en_q   <= wr_en_n;
      rd_en_q   <= rd_en_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      ready_q   <= (next_state == S_IDLE);
      busy_q    <= (next_state != S_IDLE);
      done_q    <= (next_state == S_FIN) && (next_fin == FIN_DONE);
      timeout_q <= (next_state == S_FIN) && (next_fin == FIN_TIMEOUT);
    end
  end

  // Descriptor capture at the accepting edge; later inputs are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q  <= '0;
      cnt_q  <= '0;
      dst_q  <= '0;
      dir_q  <= 1'b0;
      wait_q <= 1'b0;
    end else if ((state == S_IDLE) && bus.desc_valid) begin
      src_q  <= bus.desc_src;
      cnt_q  <= bus.desc_count;
      dst_q  <= bus.desc_dst;
      dir_q  <= bus.desc_dir;
      wait_q <= bus.desc_wait;
    end
  end

`ifdef DMA_CFG_READBACK_EN
  logic err_q;

  // Readback mismatch pulse, aligned with the FIN cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (next_state == S_FIN) && (next_fin == FIN_ERR);
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.cpu_wr_en   = wr_en_q;
  assign bus.cpu_rd_en   = rd_en_q;
  assign bus.cpu_addr    = addr_q;
  assign bus.cpu_wr_data = wdata_q;
  assign bus.desc_ready  = ready_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  // busy already covers the accepting cycle itself, but never while in reset
  assign bus.busy        = busy_q | (ready_q & bus.desc_valid & reset);

endmodule

// File: tb/tb_dma_cfg_master.sv
// tb_dma_cfg_master: randomized self-checking bench for dma_cfg_master.
// A descriptor-level model predicts the bus operation and status flags of
// every cycle; a register/status model answers the master's reads.
// Honours DMA_CFG_READBACK_EN when the design is built with it.
module tb_dma_cfg_master;
  import dma_pkg::*;

  localparam logic [31:0] STATUS = 32'h10;
  localparam int DONE_BIT = 0;
  localparam int GAP      = 4;
  localparam int TMO      = 20;
  localparam int KIND_DONE = 0;
  localparam int KIND_TMO  = 1;
  localparam int KIND_ERR  = 2;
  localparam logic [31:0] NO_BAD = 32'hFFFF_FFFF;

  logic clk;
  logic reset;
  dma_cfg_master_if bus ();

  dma_cfg_master #(
    .STATUS_ADDR  (STATUS),
    .DONE_BIT     (DONE_BIT),
    .POLL_GAP     (GAP),
    .POLL_TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int check_count = 0;
  int error_count = 0;

  // expected per-cycle behaviour of the current descriptor, offset 0 = handshake cycle
  logic        exp_wr   [64];
  logic        exp_rd   [64];
  logic [31:0] exp_addr [64];
  logic [31:0] exp_data [64];
  int          exp_end;
  int          exp_kind;

  // register / status model state
  logic [31:0] regs [4];
  int          cur_status_n = 0;
  int          status_reads = 0;
  logic        prev_status_rd = 1'b0;
  logic [31:0] status_noise = '0;
  logic [31:0] cur_bad_addr = NO_BAD;
  logic [31:0] cur_bad_mask = '0;

  // register block: remembers written values
  always_ff @(posedge clk) begin
    if (bus.cpu_wr_en && (bus.cpu_addr < 32'h10)) regs[bus.cpu_addr[3:2]] <= bus.cpu_wr_data;
  end

  // combinational read data: status done after N reads, registers optionally corrupted
  always_comb begin
    bus.cpu_rd_data = '0;
    if (bus.cpu_rd_en) begin
      if (bus.cpu_addr == STATUS) begin
        bus.cpu_rd_data = status_noise;
        bus.cpu_rd_data[DONE_BIT] = (cur_status_n != 0) && (status_reads + 1 >= cur_status_n);
      end else if (bus.cpu_addr < 32'h10) begin
        bus.cpu_rd_data = regs[bus.cpu_addr[3:2]] ^ ((bus.cpu_addr == cur_bad_addr) ? cur_bad_mask : 32'h0);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic putOp(input int cyc, input logic is_wr, input logic [31:0] addr, input logic [31:0] data);
    exp_wr[cyc]   = is_wr;
    exp_rd[cyc]   = !is_wr;
    exp_addr[cyc] = addr;
    exp_data[cyc] = data;
  endtask

  // descriptor-level reference: list of bus operations and the ending cycle
  task automatic buildExpected(input logic [31:0] src, input logic [31:0] cnt, input logic [31:0] dst,
                               input logic dir, input logic wt, input int status_n,
                               input logic [31:0] bad_addr, input logic [31:0] bad_mask);
    logic [31:0] op_addr [4];
    logic [31:0] op_data [4];
    int c;
    int reads;
    for (int i = 0; i < 64; i++) begin
      exp_wr[i] = 1'b0; exp_rd[i] = 1'b0; exp_addr[i] = '0; exp_data[i] = '0;
    end
    exp_kind = KIND_DONE;
    if (cnt == 0) begin
      exp_end = 1;
      return;
    end
    op_addr = '{32'h00, 32'h04, 32'h0C, 32'h08};
    op_data = '{src, cnt, dst, {30'b0, dir, 1'b1}};
    c = 1;
    for (int i = 0; i < 4; i++) begin
      putOp(c, 1'b1, op_addr[i], op_data[i]);
      c++;
`ifdef DMA_CFG_READBACK_EN
      putOp(c, 1'b0, op_addr[i], 32'h0);
      c++;
      if (op_addr[i] == bad_addr && i < 3 && bad_mask != 0) begin
        exp_end = c; exp_kind = KIND_ERR;
        return;
      end
      if (op_addr[i] == bad_addr && i == 3 && bad_mask[1]) begin
        putOp(c, 1'b1, 32'h08, 32'h0);
        exp_end = c + 1; exp_kind = KIND_ERR;
        return;
      end
`endif
    end
    if (!wt) begin
      exp_end = c;
      return;
    end
    reads = 0;
    for (int k = 1; k <= TMO; k++) begin
      if (k % (GAP + 1) == 0) begin
        putOp(c + k - 1, 1'b0, STATUS, 32'h0);
        reads++;
        if (status_n != 0 && reads >= status_n) begin
          exp_end = c + k;
          return;
        end
      end
      if (k == TMO) begin
        putOp(c + k, 1'b1, 32'h08, 32'h0);
        exp_end = c + k + 1; exp_kind = KIND_TMO;
        return;
      end
    end
  endtask

  task automatic checkCycle(input int off);
    logic [4:0] flags;
    flags = {off <= exp_end, off == 0 || off == exp_end + 1,
             off == exp_end && exp_kind == KIND_DONE,
             off == exp_end && exp_kind == KIND_TMO,
             off == exp_end && exp_kind == KIND_ERR};
    checkOutput($sformatf("bus@%0d", off), 64'({bus.cpu_wr_en, bus.cpu_rd_en, bus.cpu_addr}),
                64'({exp_wr[off], exp_rd[off], exp_addr[off]}));
    if (!exp_rd[off]) checkOutput($sformatf("wdata@%0d", off), 64'(bus.cpu_wr_data), 64'(exp_data[off]));
    checkOutput($sformatf("flags@%0d", off),
                64'({bus.busy, bus.desc_ready, bus.done, bus.timeout, bus.err}), 64'(flags));
  endtask

  // one descriptor: present it, then check every cycle through the return to IDLE
  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] cnt, input logic [31:0] dst,
                               input logic dir, input logic wt, input int status_n,
                               input logic [31:0] bad_addr, input logic [31:0] bad_mask);
    cur_status_n   = status_n;
    cur_bad_addr   = bad_addr;
    cur_bad_mask   = bad_mask;
    status_noise   = $urandom & ~(32'h1 << DONE_BIT);
    status_reads   = 0;
    prev_status_rd = 1'b0;
    buildExpected(src, cnt, dst, dir, wt, status_n, bad_addr, bad_mask);
    @(negedge clk);
    bus.desc_valid = 1'b1; bus.desc_src = src; bus.desc_count = cnt;
    bus.desc_dst = dst; bus.desc_dir = dir; bus.desc_wait = wt;
    #1;
    checkCycle(0);
    for (int off = 1; off <= exp_end + 1; off++) begin
      @(negedge clk);
      if (prev_status_rd) status_reads++;
      checkCycle(off);
      prev_status_rd = bus.cpu_rd_en && (bus.cpu_addr == STATUS);
      if (off < exp_end) begin
        bus.desc_valid = 1'($urandom_range(0, 1));
        bus.desc_src = $urandom; bus.desc_count = $urandom; bus.desc_dst = $urandom;
        bus.desc_dir = 1'($urandom_range(0, 1)); bus.desc_wait = 1'($urandom_range(0, 1));
      end else begin
        bus.desc_valid = 1'b0;
      end
    end
  endtask

  task automatic checkIdleReset(input string tag);
    checkOutput({tag, "_bus"}, 64'({bus.cpu_wr_en, bus.cpu_rd_en, bus.cpu_addr, bus.cpu_wr_data}), 64'h0);
    checkOutput({tag, "_flags"}, 64'({bus.busy, bus.desc_ready, bus.done, bus.timeout, bus.err}), 64'b01000);
  endtask

  // reset asserted in the middle of the destination write with desc_valid still high
  task automatic resetMidWrite();
    int dst_off;
`ifdef DMA_CFG_READBACK_EN
    dst_off = 5;
`else
    dst_off = 3;
`endif
    @(negedge clk);
    bus.desc_valid = 1'b1; bus.desc_src = 32'hA0; bus.desc_count = 32'h10;
    bus.desc_dst = 32'hB0; bus.desc_dir = 1'b1; bus.desc_wait = 1'b1;
    repeat (dst_off) @(negedge clk);
    checkOutput("rst_pre_dst", 64'({bus.cpu_wr_en, bus.cpu_addr, bus.cpu_wr_data}), 64'({1'b1, 32'h0C, 32'hB0}));
    reset = 1'b0;
    #1;
    checkIdleReset("rst_async");
    repeat (2) @(negedge clk);
    checkIdleReset("rst_held");
    bus.desc_valid = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkIdleReset($sformatf("rst_after%0d", i));
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.desc_valid = 1'b0; bus.desc_src = '0; bus.desc_count = '0;
    bus.desc_dst = '0; bus.desc_dir = 1'b0; bus.desc_wait = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleReset("reset_state");
    reset = 1'b1;
    @(negedge clk);
    checkIdleReset("after_release");

    $display("[TB] directed descriptors");
    applyStimulus(32'h1000, 32'd8, 32'h2000, 1'b1, 1'b0, 0, NO_BAD, 32'h0);
    applyStimulus(32'h3000, 32'd5, 32'h4000, 1'b0, 1'b1, 3, NO_BAD, 32'h0);
    applyStimulus(32'h5000, 32'd7, 32'h6000, 1'b1, 1'b1, 0, NO_BAD, 32'h0);
    applyStimulus(32'h7000, 32'd0, 32'h8000, 1'b1, 1'b1, 1, NO_BAD, 32'h0);
    applyStimulus(32'h9000, 32'd3, 32'hA000, 1'b0, 1'b1, 4, NO_BAD, 32'h0);
    applyStimulus(32'hB000, 32'hFFFF_FFFF, 32'hC000, 1'b1, 1'b1, 1, NO_BAD, 32'h0);

    $display("[TB] reset during destination write");
    resetMidWrite();

`ifdef DMA_CFG_READBACK_EN
    $display("[TB] readback corruption");
    applyStimulus(32'h1000, 32'd8, 32'h2000, 1'b1, 1'b0, 0, 32'h04, 32'h0000_0100);
    applyStimulus(32'h1000, 32'd8, 32'h2000, 1'b1, 1'b1, 2, 32'h08, 32'h0000_0002);
    applyStimulus(32'h1000, 32'd8, 32'h2000, 1'b0, 1'b1, 2, 32'h08, 32'h0000_0008);
`endif

    $display("[TB] random descriptors");
    for (int n = 0; n < 30; n++) begin
      logic [31:0] cnt;
      logic [31:0] bad_addr;
      logic [31:0] bad_mask;
      cnt = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      bad_addr = NO_BAD;
      bad_mask = '0;
`ifdef DMA_CFG_READBACK_EN
      if ($urandom_range(0, 2) == 0) begin
        bad_addr = 32'(4 * $urandom_range(0, 3));
        bad_mask = $urandom;
      end
`endif
      applyStimulus($urandom, cnt, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 5)), bad_addr, bad_mask);
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
